// File: rtl/nvm_reader.sv
// nvm_reader: 32x8 read-only memory streamed out as UART-style serial frames while Read is high
// Ports: CLK clock; RST sync active-high reset; Read stream enable (level);
//        Addr word address, sampled only in LOAD/STOP; DATA serial out, idles at 1.
// Build option: define NVM_READER_PARITY_EN to insert an even-parity bit after the last data bit.
module nvm_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Read,
   input  logic [ADDR_W-1:0] Addr,
   output logic              DATA
);
   localparam int IW = $clog2(DATA_W);
   localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
   typedef enum logic [2:0] {IDLE, LOAD, START, BIT, PARITY, STOP} state_t;
`ifdef NVM_READER_PARITY_EN
   localparam state_t AFTER_BITS = PARITY;
`else
   localparam state_t AFTER_BITS = STOP;
`endif
   state_t state, state_n;
   logic [IW-1:0] idx;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always_comb
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(2 * i);
   // STOP loops straight back to START so back-to-back frames have no idle gap
   always_comb begin
      state_n = !Read           ? IDLE :
                state == IDLE   ? LOAD :
                state == LOAD   ? START :
                state == START  ? BIT :
                state == BIT    ? (idx == LAST ? AFTER_BITS : BIT) :
                state == PARITY ? STOP : START;
   end
   // Gating on RST/Read is combinational so the line returns to mark before any edge
   always_comb begin
      DATA = (RST || !Read)    ? 1'b1 :
             state == START    ? 1'b0 :
             state == BIT      ? shift[idx] :
             state == PARITY   ? ^shift : 1'b1;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         idx   <= state == BIT ? idx + 1'b1 : '0;
         if (Read && (state == LOAD || state == STOP)) shift <= mem[Addr];
      end
   end
endmodule

// File: tb/tb_nvm_reader.sv
// tb_nvm_reader: scoreboard bench for nvm_reader serial frames
module tb_nvm_reader;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Read = 1'b0;
   logic [4:0] Addr = '0;
   logic       DATA;
   int n_cmp = 0;
   int n_err = 0;
   logic q[$];

   nvm_reader dut (.CLK(CLK), .RST(RST), .Read(Read), .Addr(Addr), .DATA(DATA));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [4:0] a);
      return 8'((a * 2) % 256);
   endfunction

   // Drive inputs for the next cycle and queue the DATA value expected during it
   task automatic step(input logic r, input logic rd, input logic [4:0] a, input logic e);
      @(posedge CLK);
      #1;
      RST = r;
      Read = rd;
      Addr = a;
      q.push_back(e);
   endtask

   // One full frame; Addr switches from a0 to a1 starting at data bit sw
   task automatic frame(input logic [7:0] b, input logic [4:0] a0, input logic [4:0] a1, input int sw);
      step(1'b0, 1'b1, a0, 1'b0);
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, k >= sw ? a1 : a0, b[k]);
`ifdef NVM_READER_PARITY_EN
      step(1'b0, 1'b1, a1, ^b);
`endif
      step(1'b0, 1'b1, a1, 1'b1);
   endtask

   always @(negedge CLK)
      if (q.size() > 0) check("data", DATA, q.pop_front());

   initial begin
      #1;
      check("rst_first_cycle", DATA, 1'b1);
      step(1'b1, 1'b0, 5'd0, 1'b1);
      step(1'b1, 1'b0, 5'd0, 1'b1);
      // single frame from address 1: IDLE cycle, LOAD cycle, then frame
      step(1'b0, 1'b1, 5'd1, 1'b1);
      step(1'b0, 1'b1, 5'd1, 1'b1);
      frame(model(5'd1), 5'd1, 5'd1, 99);
      // second frame starts, then Read drops during bit 2
      step(1'b0, 1'b1, 5'd1, 1'b0);
      step(1'b0, 1'b1, 5'd1, 1'b0);
      step(1'b0, 1'b1, 5'd1, 1'b1);
      step(1'b0, 1'b0, 5'd3, 1'b1);
      step(1'b0, 1'b1, 5'd3, 1'b1);
      step(1'b0, 1'b1, 5'd3, 1'b1);
      frame(model(5'd3), 5'd3, 5'd31, 99);
      // streaming: address changes mid-frame, affects only the next frame
      frame(model(5'd31), 5'd31, 5'd1, 4);
      frame(model(5'd1), 5'd1, 5'd1, 99);
      // reset during bit 2 of the following frame
      step(1'b0, 1'b1, 5'd1, 1'b0);
      step(1'b0, 1'b1, 5'd1, 1'b0);
      step(1'b0, 1'b1, 5'd1, 1'b1);
      step(1'b1, 1'b1, 5'd1, 1'b1);
      step(1'b0, 1'b1, 5'd1, 1'b1);
      step(1'b0, 1'b1, 5'd1, 1'b1);
      frame(model(5'd1), 5'd1, 5'd1, 99);
      step(1'b0, 1'b0, 5'd0, 1'b1);
      step(1'b0, 1'b0, 5'd0, 1'b1);
      @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d queued values left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
